iterative_shifter: RTL
======================

// Module: iterative_shifter
// PURPOSE
//   Multi-cycle, parametrised logical/arithmetic shifter for the ALU datapath.
//   Generalises the fixed 1-bit left-shift stages to any power-of-two WIDTH.
//   Supports SLL, SRL and SRA by a runtime amount, consuming shamt bits over several cycles.
//   Uses a valid/ready handshake on input and output, so the pipeline can stall around it.
// PARAMETERS
//   WIDTH             32  data width; must be a power of two, >= 2
//   STAGES_PER_CYCLE  1   shamt bits retired per BUSY cycle, 1..SHAMT_W
//   (localparam) SHAMT_W = $clog2(WIDTH)
//   (localparam) NCYC    = ceil(SHAMT_W / STAGES_PER_CYCLE)
// PORTS
//   clock      in   1        single clock; all state updates on its rising edge
//   reset      in   1        synchronous, active-high
//   in_valid   in   1        request present
//   in_ready   out  1        block can accept a request
//   in_data    in   WIDTH    operand
//   in_shamt   in   SHAMT_W  shift amount, unsigned
//   in_op      in   2        00 SLL, 01 SRL, 10 SRA, 11 ROL (see CONFIGURATION)
//   out_valid  out  1        result present
//   out_ready  in   1        consumer takes result
//   out_data   out  WIDTH    result
//   busy       out  1        high in BUSY or DONE
// BEHAVIOUR
// - FSM states are IDLE, BUSY and DONE. Reset (sampled at an edge) forces IDLE from any state, clears acc, out_data and cnt.
// - Output values while reset is held: out_valid=0, busy=0, out_data=0, in_ready=0 (in_ready = IDLE & ~reset).
// - IDLE:
//   - in_ready=1.
//   - On in_valid&in_ready, latch in_data->acc, in_shamt, in_op; cnt=0; go to BUSY.
// - BUSY:
//   - Each cycle, apply stages k = cnt*S .. min(cnt*S+S, SHAMT_W)-1 in ascending order (S = STAGES_PER_CYCLE).
//   - For each stage k, if shamt[k]=1, shift acc by 2^k per the op:
//     - SLL: zero-fill at the LSB end.
//     - SRL: zero-fill at the MSB end.
//     - SRA: fill with the operand's original MSB.
//   - cnt increments each cycle. After cycle NCYC-1, go to DONE.
//   - in_ready=0. in_valid is ignored, with no queueing.
// - DONE:
//   - out_valid=1, with out_data=acc held stable.
//   - On out_ready, go to IDLE (out_valid drops next cycle).
//   - Without out_ready, hold indefinitely.
// - Latency: a request accepted at edge N gives out_valid=1 after edge N+NCYC+1 (one edge to leave IDLE, NCYC BUSY edges).
//   - This holds for every shamt, including 0, with no early exit.
// - Throughput: one request per NCYC+2 cycles minimum, since IDLE must be re-entered before the next accept.
// - out_data keeps the last result after DONE->IDLE until the next DONE. Only reset clears it.
// - Result width is exactly WIDTH. Bits shifted out are discarded; no carry or overflow output.
// - Reset while in BUSY or DONE drops the transaction silently; no partial result is ever exposed.
// CONFIGURATION
// - Macro SHIFTER_ROTATE_EN:
//   - Defined: op 11 = rotate left (bits leaving the MSB re-enter at the LSB), same stages and latency.
//   - Undefined: op 11 behaves exactly as SLL; rotate logic is absent.
// TESTING  (WIDTH=32, STAGES_PER_CYCLE=1, NCYC=5)
// - SLL 0x0000_0001 shamt 31 -> out_data=0x8000_0000, out_valid 6 cycles after accept.
// - SRA 0x8000_0000 shamt 4 -> 0xF800_0000; SRL same -> 0x0800_0000; SRA 0x7FFF_FFFF shamt 31 -> 0.
// - Any op, in_data 0xDEAD_BEEF shamt 0 -> 0xDEAD_BEEF, still full 6-cycle latency.
// - Hold out_ready=0 for 10 cycles in DONE, with in_valid=1 and new data:
//   - out_data stays stable, in_ready=0, the new request is not taken.
//   - Release out_ready: IDLE next cycle, then the new request is accepted.
// - Assert reset in the 3rd BUSY cycle:
//   - Next cycle out_valid=0, busy=0, out_data=0.
//   - Then in_ready=1; SLL 0x3 by 2 -> 0x0000_000C.
// - STAGES_PER_CYCLE=2 (NCYC=3): SLL 1 shamt 31 -> 0x8000_0000, out_valid 4 cycles after accept.
// - With SHIFTER_ROTATE_EN: op 11 on 0x8000_0001 shamt 1 -> 0x0000_0003. Without it: 0x0000_0002.

Source files
------------

// File: rtl/iterative_shifter.sv
// ---------------------------------------------------------------------------------------------
// iterative_shifter
//
// Multi-cycle logical/arithmetic shifter for the ALU datapath. The shift amount is consumed a
// few bits at a time: each BUSY cycle applies the binary-weighted stages (shift by 2^k) for
// STAGES_PER_CYCLE consecutive shamt bits. This keeps a one-stage (or few-stage) shifter in
// place of a full barrel shifter. Every request takes the same number of cycles, whatever its
// shift amount.
//
// Parameters
//   WIDTH             data width, power of two, >= 2
//   STAGES_PER_CYCLE  shamt bits retired per BUSY cycle, 1..SHAMT_W
//   SHAMT_W           (derived) $clog2(WIDTH)
//   NCYC              (derived) number of BUSY cycles, ceil(SHAMT_W / STAGES_PER_CYCLE)
//
// Ports
//   clock      in   1        rising-edge clock
//   reset      in   1        synchronous, active-high; also masks the status outputs while held
//   in_valid   in   1        request present
//   in_ready   out  1        block is idle and can accept a request
//   in_data    in   WIDTH    operand
//   in_shamt   in   SHAMT_W  unsigned shift amount
//   in_op      in   2        00 SLL, 01 SRL, 10 SRA, 11 ROL (or SLL, see below)
//   out_valid  out  1        result present
//   out_ready  in   1        consumer takes the result
//   out_data   out  WIDTH    result; holds the last result until the next one or a reset
//   busy       out  1        a request is in flight or waiting to be taken
//
// Configuration
//   SHIFTER_ROTATE_EN  when defined, op 11 rotates left with the same stages and latency.
//                      When undefined, op 11 is an ordinary SLL and no rotate logic exists.
// ---------------------------------------------------------------------------------------------
module iterative_shifter #(
  parameter int unsigned WIDTH            = 32,
  parameter int unsigned STAGES_PER_CYCLE = 1,
  localparam int unsigned SHAMT_W         = $clog2(WIDTH)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               busy
);

  localparam int unsigned NCYC  = (SHAMT_W + STAGES_PER_CYCLE - 1) / STAGES_PER_CYCLE;
  // Wide enough to hold NCYC itself, so the NCYC == 1 case still gets a 1-bit counter.
  localparam int unsigned CNT_W = $clog2(NCYC + 1);

  localparam logic [1:0] OpSll = 2'b00;
  localparam logic [1:0] OpSrl = 2'b01;
  localparam logic [1:0] OpSra = 2'b10;
`ifdef SHIFTER_ROTATE_EN
  localparam logic [1:0] OpRol = 2'b11;
`endif

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   out_data_q, out_data_d;
  logic [SHAMT_W-1:0] shamt_q, shamt_d;
  logic [1:0]         op_q, op_d;
  logic               sign_q, sign_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [WIDTH-1:0]   acc_step;
  logic [SHAMT_W-1:0] shamt_bits;
  logic               last_cycle;

  // One binary-weighted stage: shift a by 2^k according to op.
  function automatic logic [WIDTH-1:0] stage_shift(input logic [WIDTH-1:0] a,
                                                   input logic [1:0]       op,
                                                   input logic             sign,
                                                   input int unsigned      k);
    int unsigned      amt;
    logic [WIDTH-1:0] fill;
    logic [WIDTH-1:0] r;
    amt  = 32'd1 << k;
    // Ones in the top amt positions when the original operand was negative.
    fill = sign ? ~({WIDTH{1'b1}} >> amt) : '0;
    case (op)
      OpSll:   r = a << amt;
      OpSrl:   r = a >> amt;
      OpSra:   r = (a >> amt) | fill;
`ifdef SHIFTER_ROTATE_EN
      // amt <= WIDTH/2 here, so WIDTH - amt never reaches zero.
      OpRol:   r = (a << amt) | (a >> (WIDTH - amt));
`endif
      default: r = a << amt;
    endcase
    return r;
  endfunction

  // Apply the stages owned by this cycle (k / STAGES_PER_CYCLE == cnt) in ascending k order.
  // Indices past SHAMT_W - 1 simply do not exist, which covers a short final cycle.
  always_comb begin
    acc_step   = acc_q;
    shamt_bits = '0;
    for (int unsigned k = 0; k < SHAMT_W; k++) begin
      shamt_bits = shamt_q >> k;
      if (((k / STAGES_PER_CYCLE) == 32'(cnt_q)) && shamt_bits[0]) begin
        acc_step = stage_shift(acc_step, op_q, sign_q, k);
      end
    end
  end

  assign last_cycle = (cnt_q == CNT_W'(NCYC - 1));

  // Next-state logic.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    out_data_d = out_data_q;
    shamt_d    = shamt_q;
    op_d       = op_q;
    sign_d     = sign_q;
    cnt_d      = cnt_q;

    case (state_q)
      StIdle: begin
        if (in_valid && in_ready) begin
          acc_d   = in_data;
          shamt_d = in_shamt;
          op_d    = in_op;
          sign_d  = in_data[WIDTH-1];
          cnt_d   = '0;
          state_d = StBusy;
        end
      end
      StBusy: begin
        acc_d = acc_step;
        cnt_d = cnt_q + CNT_W'(1);
        if (last_cycle) begin
          // Result register only changes here, so no partial value is ever visible.
          out_data_d = acc_step;
          state_d    = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      acc_q      <= '0;
      out_data_q <= '0;
      shamt_q    <= '0;
      op_q       <= 2'b00;
      sign_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      out_data_q <= out_data_d;
      shamt_q    <= shamt_d;
      op_q       <= op_d;
      sign_q     <= sign_d;
      cnt_q      <= cnt_d;
    end
  end

  // Status outputs are masked while reset is held, so a reset during BUSY/DONE is visible
  // in the same cycle rather than one edge later.
  always_comb begin
    in_ready  = (state_q == StIdle) && !reset;
    out_valid = (state_q == StDone) && !reset;
    busy      = (state_q != StIdle) && !reset;
    out_data  = reset ? '0 : out_data_q;
  end

endmodule
